uart_upgrade_loader: RTL
========================

// Module: uart_upgrade_loader
// PURPOSE
//  SoC-side receiver for the UART firmware-upgrade stream. While upgrade mode is on, it takes
//  bytes from the SoC UART receiver, packs them little-endian into XLEN-bit words and writes them
//  to instruction RAM. It holds the CPU until RAM_SIZE bytes have landed, then releases it.
//  Sits between the uart rx side and the RAM write port, gated by ~sw_uart_upgrade_b.
// PARAMETERS
//  XLEN            32       RAM word width (bits); must be 32
//  RAM_SIZE        16'h4000 image size in bytes; multiple of 4
//  ADDR_W          14       byte-address width, $clog2(RAM_SIZE)
//  TIMEOUT_CYCLES  200000   max idle gap between bytes once loading has started
// PORTS
//  clk        in   1         single clock
//  rst        in   1         reset, asynchronous, active-high
//  en         in   1         upgrade mode request (driven from ~sw_uart_upgrade_b)
//  rx_valid   in   1         one-cycle strobe per received byte
//  rx_data    in   8         received byte
//  ram_we     out  1         RAM word write strobe
//  ram_addr   out  ADDR_W-2  RAM word address
//  ram_wdata  out  XLEN      RAM write data
//  cpu_hold   out  1         keep CPU in reset
//  done       out  1         full image written
//  err        out  1         inter-byte timeout; image incomplete
//  checksum   out  8         mod-256 sum of accepted bytes
// BEHAVIOUR
//  States: IDLE, LOAD, DONE, ERR (enum in package).
//  Reset: state=IDLE, byte_cnt=0, gap_cnt=0, ram_we=0, ram_addr=0, ram_wdata=0, done=0, err=0,
//    checksum=0.
//  cpu_hold = (IDLE & en) | LOAD | ERR. This is a combinational decode, so the CPU is held from
//    the first cycle of en.
//  IDLE: en=1 -> LOAD next cycle, with byte_cnt, checksum and gap_cnt cleared. rx_valid is ignored.
//  LOAD: each cycle with rx_valid=1 accepts exactly one byte:
//    - lane = byte_cnt[1:0]; shift reg[8*lane+:8] <= rx_data
//    - checksum += rx_data; byte_cnt += 1; gap_cnt <= 0
//    - lane==3: next cycle ram_we=1 for exactly 1 cycle, with ram_addr=byte_cnt[ADDR_W-1:2] of
//      that byte and ram_wdata equal to the 4 packed bytes. Write latency is 1 cycle.
//    - last byte (byte_cnt==RAM_SIZE-1): after the final write -> DONE, same edge as ram_we=1.
//    - a byte arriving in the cycle ram_we is high is accepted normally; the output regs are
//      independent of the pack reg.
//  Timeout: gap_cnt runs only after >=1 byte has been accepted (byte_cnt!=0). It saturates at
//    TIMEOUT_CYCLES; on reaching it -> ERR and the partial word is discarded (no write).
//    Before the first byte the loader waits indefinitely.
//  DONE: done=1, cpu_hold=0. Further rx_valid is ignored; no RAM writes.
//  ERR: err=1, cpu_hold=1. rx_valid is ignored.
//  en=0 in any state -> IDLE next cycle, clearing done and err. An in-flight partial word is
//    dropped. A ram_we already scheduled still completes. Re-asserting en restarts from address 0.
//  rst mid-LOAD: immediate return to reset values; no ram_we pulse follows.
//  byte_cnt is ADDR_W+1 bits wide, so RAM_SIZE is representable and no wrap occurs.
// STRUCTURE
//  soc_pkg: loader_state_t {IDLE,LOAD,DONE,ERR}, LOADER_RAM_SIZE, LOADER_TIMEOUT default.
//  Single module. The gap timer and byte packer are inline; no sub-module warranted.
// TESTING (bench: uart tx model at baudrate_cfg=6 -> uart rx -> loader; RAM_SIZE=16, TIMEOUT=2000)
//  1. en=1, stream bytes 00..0F -> 4 ram_we pulses: addr0=32'h03020100 ... addr3=32'h0F0E0D0C;
//     then done=1, cpu_hold=0, checksum=8'h78.
//  2. en=1, 6 bytes, then silence >2000 cycles -> err=1, cpu_hold=1, exactly 1 ram_we (addr0).
//     Bytes 4-5 are not written.
//  3. en=1, 10 bytes, then en=0 for 5 cycles, then en=1 and a full 16-byte stream -> done=1.
//     The first write of the second pass has addr=0. Total ram_we count is 2+4.
//  4. en=1, idle 10000 cycles with no bytes -> no err, cpu_hold=1; then a full stream -> done=1.
//  5. After DONE, send 4 more bytes -> no ram_we, checksum unchanged, done stays 1.
//  6. Assert rst for 1 cycle after byte 7 -> all outputs at reset values, no ram_we.
//     Release with en=1 -> cpu_hold=1 and the load restarts at addr 0.

Source files
------------

// File: rtl/uart_upgrade_loader_pkg.sv
// Shared types and defaults for the UART firmware-upgrade loader.
//   loader_state_t   : loader FSM states
//   LOADER_RAM_SIZE  : default image size in bytes
//   LOADER_TIMEOUT   : default inter-byte idle limit in clock cycles
package uart_upgrade_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } loader_state_t;

  localparam int LOADER_RAM_SIZE = 16'h4000;
  localparam int LOADER_TIMEOUT  = 200000;

endpackage

// File: rtl/uart_upgrade_loader.sv
// UART firmware-upgrade loader.
// Takes one byte per rx_valid strobe while upgrade mode (en) is on, packs bytes
// little-endian into 32-bit words and writes each completed word to
// instruction RAM one cycle after its last byte arrives. The CPU is held in
// reset until RAM_SIZE bytes have been written; an inter-byte gap longer than
// TIMEOUT_CYCLES (after the first byte) aborts the load with err.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   en         in   upgrade mode request
//   rx_valid   in   one-cycle strobe per received byte
//   rx_data    in   received byte
//   ram_we     out  RAM word write strobe (one cycle per word)
//   ram_addr   out  RAM word address
//   ram_wdata  out  RAM write data
//   cpu_hold   out  keep CPU in reset
//   done       out  full image written
//   err        out  inter-byte timeout, image incomplete
//   checksum   out  mod-256 sum of accepted bytes
//   dbg_state  out  current FSM state (loader_state_t encoding)
//
// Handshake: rx_valid has no back-pressure; every cycle with rx_valid=1 in
// LOAD (and en=1) consumes rx_data exactly once. ram_we is a single-cycle
// strobe with ram_addr/ram_wdata valid in the same cycle; the RAM is assumed
// to always accept.
module uart_upgrade_loader
  import uart_upgrade_loader_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int RAM_SIZE       = LOADER_RAM_SIZE,
  parameter int ADDR_W         = 14,
  parameter int TIMEOUT_CYCLES = LOADER_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              ram_we,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [XLEN-1:0]   ram_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [7:0]        checksum,
  output logic [1:0]        dbg_state
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W:0]  LAST_BYTE = (ADDR_W + 1)'(RAM_SIZE - 1);
  localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(TIMEOUT_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);

  loader_state_t     state_q, state_d;
  logic [ADDR_W:0]   byte_cnt_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  // Only lanes 0..2 need storage; lane 3 goes straight from rx_data to RAM.
  logic [XLEN-9:0]   pack_q;

  logic              start;
  logic              accept;
  logic              lane3;
  logic              last_byte;
  logic              gap_run;
  logic              gap_hit;

  always_comb begin
    start     = 1'b0;
    accept    = 1'b0;
    gap_run   = 1'b0;
    gap_hit   = 1'b0;
    lane3     = (byte_cnt_q[1:0] == 2'd3);
    last_byte = (byte_cnt_q == LAST_BYTE);
    state_d   = state_q;

    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          start   = 1'b1;
          state_d = LOAD;
        end
        LOAD: begin
          accept = rx_valid;
          // The idle timer only arms once the stream has actually started.
          gap_run = !rx_valid && (byte_cnt_q != '0);
          gap_hit = gap_run && (gap_cnt_q == GAP_LAST);
          if (accept && last_byte) begin
            state_d = DONE;
          end else if (gap_hit) begin
            state_d = ERR;
          end
        end
        DONE:    state_d = DONE;
        ERR:     state_d = ERR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      pack_q     <= '0;
      checksum   <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      state_q <= state_d;
      ram_we  <= accept && lane3;

      // Write port registers are separate from the pack register, so a byte
      // arriving while ram_we is high refills lane 0 without disturbing it.
      if (accept && lane3) begin
        ram_addr  <= byte_cnt_q[ADDR_W-1:2];
        ram_wdata <= {rx_data, pack_q};
      end

      if (start) begin
        byte_cnt_q <= '0;
        gap_cnt_q  <= '0;
        checksum   <= '0;
      end else if (accept) begin
        if (!lane3) begin
          pack_q[{byte_cnt_q[1:0], 3'b000} +: 8] <= rx_data;
        end
        checksum   <= checksum + rx_data;
        byte_cnt_q <= byte_cnt_q + (ADDR_W + 1)'(1);
        gap_cnt_q  <= '0;
      end else if (gap_run && (gap_cnt_q != GAP_MAX)) begin
        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
      end
    end
  end

  assign cpu_hold  = ((state_q == IDLE) && en) || (state_q == LOAD) || (state_q == ERR);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign dbg_state = state_q;

endmodule
